ipif_reg_master: RTL and testbench

IPIF_REG_MASTER -- requirements
Module: ipif_reg_master

---
 rtl/ipif_master_pkg.sv | 20 ++
 rtl/ipif_timeout_cnt.sv | 32 +++
 rtl/ipif_reg_master.sv | 125 ++++++++++++
 tb/tb_ipif_reg_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipif_master_pkg.sv
// Shared definitions for the IPIF register master: state encoding, timeout
// defaults and the saturating timed-out transaction counter helper.
package ipif_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } ipif_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 256;
  localparam int TIMEOUT_COUNT_W        = 16;

  function automatic logic [TIMEOUT_COUNT_W-1:0] sat_inc(
    input logic [TIMEOUT_COUNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ipif_timeout_cnt.sv
// Per-transaction ACCESS cycle counter; expired marks the last allowed
// ACCESS cycle so the master can leave on that same edge.
module ipif_timeout_cnt
  import ipif_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic Bus2IP_Clk,
  input  logic Bus2IP_Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/ipif_reg_master.sv
// Single-outstanding IPIF register master: accepts a command, drives one
// chip-select access with timeout, and holds the response until taken.
module ipif_reg_master
  import ipif_master_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                            Bus2IP_Clk,
  input  logic                            Bus2IP_Reset,
  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; valid never waits on ready, and ready is registered.
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_rnw,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] cmd_be,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                            rsp_error,
  output logic                            rsp_timeout,
  output logic                            Bus2IP_CS,
  output logic                            Bus2IP_RNW,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data,
  input  logic                            IP2Bus_RdAck,
  input  logic                            IP2Bus_WrAck,
  input  logic                            IP2Bus_Error,
  output logic [TIMEOUT_COUNT_W-1:0]      timeout_count,
  output ipif_state_e                     dbg_state
);

  localparam int BE_W = C_S_AXI_DATA_WIDTH / 8;

  ipif_state_e                   state_q, state_d;
  logic                          cmd_ready_q;
  logic                          rnw_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [BE_W-1:0]               be_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                          error_q;
  logic                          timeout_q;
  logic [TIMEOUT_COUNT_W-1:0]    timeout_count_q;

  logic cmd_accept;
  logic ack_ok;
  logic expired;
  logic finish_access;

  assign cmd_accept    = cmd_valid && cmd_ready_q;
  // Only the ack matching the registered direction completes an access.
  assign ack_ok        = rnw_q ? IP2Bus_RdAck : IP2Bus_WrAck;
  assign finish_access = (state_q == ACCESS) && (state_d == RESP);

  ipif_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .Bus2IP_Clk  (Bus2IP_Clk),
    .Bus2IP_Reset(Bus2IP_Reset),
    .clear       (cmd_accept),
    .enable      (state_q == ACCESS),
    .expired     (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_accept) state_d = ACCESS;
      ACCESS:  if (ack_ok || expired) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state_q         <= IDLE;
      cmd_ready_q     <= 1'b0;
      rnw_q           <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      be_q            <= '0;
      rdata_q         <= '0;
      error_q         <= 1'b0;
      timeout_q       <= 1'b0;
      timeout_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == IDLE);
      if (cmd_accept) begin
        rnw_q   <= cmd_rnw;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        be_q    <= cmd_be;
      end
      // An ack coinciding with expiry wins: ack_ok is checked first.
      if (finish_access) begin
        rdata_q   <= (ack_ok && rnw_q) ? IP2Bus_Data : '0;
        error_q   <= ack_ok && IP2Bus_Error;
        timeout_q <= !ack_ok;
        if (!ack_ok) timeout_count_q <= sat_inc(timeout_count_q);
      end
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_error     = error_q;
  assign rsp_timeout   = timeout_q;
  assign Bus2IP_CS     = (state_q == ACCESS);
  assign Bus2IP_RNW    = rnw_q;
  assign Bus2IP_Addr   = addr_q;
  assign Bus2IP_Data   = rnw_q ? '0 : wdata_q;
  assign Bus2IP_BE     = be_q;
  assign timeout_count = timeout_count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ipif_reg_master.sv
// Directed bench for ipif_reg_master with a small registered IPIF responder
// model; checks are taken at the falling edge, inputs change there too.
module tb_ipif_reg_master;
  import ipif_master_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
  logic [AW-1:0]     cmd_addr = '0;
  logic [DW-1:0]     cmd_wdata = '0;
  logic [DW/8-1:0]   cmd_be = '0;
  logic              rsp_valid, rsp_ready = 1'b1;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_error, rsp_timeout;
  logic              cs, rnw;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     bdata;
  logic [DW/8-1:0]   be;
  logic [DW-1:0]     ip_data = '0;
  logic              rdack = 1'b0, wrack = 1'b0, ip_err = 1'b0;
  logic [15:0]       timeout_count;
  ipif_state_e       dbg_state;

  // Responder controls
  logic              resp_en = 1'b1, resp_wrong = 1'b0, resp_err = 1'b0;
  int                resp_delay = 1;
  logic [DW-1:0]     rd_val = '0;
  int                seen = 0;
  logic              fire;

  int vectors = 0;
  int miscompares = 0;

  ipif_reg_master #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .Bus2IP_Clk   (clk),
    .Bus2IP_Reset (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rnw      (cmd_rnw),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_be       (cmd_be),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .rsp_timeout  (rsp_timeout),
    .Bus2IP_CS    (cs),
    .Bus2IP_RNW   (rnw),
    .Bus2IP_Addr  (addr),
    .Bus2IP_Data  (bdata),
    .Bus2IP_BE    (be),
    .IP2Bus_Data  (ip_data),
    .IP2Bus_RdAck (rdack),
    .IP2Bus_WrAck (wrack),
    .IP2Bus_Error (ip_err),
    .timeout_count(timeout_count),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish by 50000ns, expected finish");
    $fatal(1);
  end

  // Responder: acks in the cycle after CS has been seen high resp_delay times,
  // and keeps acking while CS stays high (the one-cycle overlap duplicate).
  assign fire = cs && resp_en && (seen + 1 >= resp_delay);

  always @(posedge clk) begin
    seen    <= cs ? seen + 1 : 0;
    rdack   <= fire && (rnw ^ resp_wrong);
    wrack   <= fire && !(rnw ^ resp_wrong);
    ip_data <= (fire && rnw) ? rd_val : '0;
    ip_err  <= fire && resp_err;
  end

  // Scoreboard-style comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Driver: called at a falling edge; returns at the falling edge of the
  // first cycle after acceptance (t+1).
  task automatic issue(input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW/8-1:0] b);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_rnw   = r;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_be    = b;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_tcount", 32'(timeout_count), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write 0xDEADBEEF to 0x04
    issue(1'b0, 32'h04, 32'hDEADBEEF, 4'hF);
    chk("wr_s1_cs", 32'(cs), 32'd1);
    chk("wr_s1_rnw", 32'(rnw), 32'd0);
    chk("wr_s1_addr", addr, 32'h04);
    chk("wr_s1_data", bdata, 32'hDEADBEEF);
    chk("wr_s1_be", 32'(be), 32'hF);
    chk("wr_s1_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("wr_s2_cs", 32'(cs), 32'd1);
    chk("wr_s2_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("wr_s3_cs", 32'(cs), 32'd0);
    chk("wr_s3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_s3_err", 32'(rsp_error), 32'd0);
    chk("wr_s3_rdata", rsp_rdata, 32'd0);
    chk("wr_s3_timeout", 32'(rsp_timeout), 32'd0);
    tick();
    chk("wr_s4_cs", 32'(cs), 32'd0);
    chk("wr_s4_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wr_s4_cmd_ready", 32'(cmd_ready), 32'd1);

    // Read 0x08 returning 0x12345678
    rd_val = 32'h12345678;
    issue(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF);
    chk("rd_s1_rnw", 32'(rnw), 32'd1);
    chk("rd_s1_data_zero", bdata, 32'd0);
    chk("rd_s1_addr", addr, 32'h08);
    tick();
    chk("rd_s2_cs", 32'(cs), 32'd1);
    tick();
    chk("rd_s3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_s3_rdata", rsp_rdata, 32'h12345678);
    chk("rd_s3_timeout", 32'(rsp_timeout), 32'd0);
    chk("rd_s3_cs", 32'(cs), 32'd0);
    tick();
    chk("rd_s4_cs", 32'(cs), 32'd0);
    chk("rd_s4_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("rd_s5_cs", 32'(cs), 32'd0);
    chk("rd_s5_rsp_valid", 32'(rsp_valid), 32'd0);

    // Silent responder: timeout after 4 ACCESS cycles
    resp_en = 1'b0;
    rd_val  = 32'hCAFEF00D;
    issue(1'b1, 32'h20, 32'd0, 4'hF);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to_cs_cycle%0d", i), 32'(cs), 32'd1);
      tick();
    end
    chk("to_s5_cs", 32'(cs), 32'd0);
    chk("to_s5_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_s5_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_s5_err", 32'(rsp_error), 32'd0);
    chk("to_s5_rdata", rsp_rdata, 32'd0);
    chk("to_s5_tcount", 32'(timeout_count), 32'd1);
    tick();
    resp_en = 1'b1;

    // Write with slave error, response held 10 cycles
    resp_err  = 1'b1;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0C, 32'h0000A5A5, 4'h3);
    tick();
    tick();
    chk("hold_s3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("hold_s3_err", 32'(rsp_error), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold_valid_%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold_err_%0d", i), 32'(rsp_error), 32'd1);
      chk($sformatf("hold_rdata_%0d", i), rsp_rdata, 32'd0);
      chk($sformatf("hold_cmd_ready_%0d", i), 32'(cmd_ready), 32'd0);
      chk($sformatf("hold_cs_%0d", i), 32'(cs), 32'd0);
    end
    rsp_ready = 1'b1;
    resp_err  = 1'b0;
    tick();
    chk("hold_rel_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hold_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("hold_rel_cs", 32'(cs), 32'd0);

    // Wrong-direction ack (WrAck to a read) is ignored and times out
    resp_wrong = 1'b1;
    issue(1'b1, 32'h30, 32'd0, 4'hF);
    for (int i = 1; i <= 4; i++) tick();
    chk("wrong_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wrong_timeout", 32'(rsp_timeout), 32'd1);
    chk("wrong_err", 32'(rsp_error), 32'd0);
    chk("wrong_tcount", 32'(timeout_count), 32'd2);
    tick();
    resp_wrong = 1'b0;

    // Reset during ACCESS abandons the transaction
    rd_val = 32'hAAAA5555;
    issue(1'b1, 32'h40, 32'd0, 4'hF);
    chk("rst_acc_s1_cs", 32'(cs), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_acc_cs", 32'(cs), 32'd0);
    chk("rst_acc_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_acc_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_acc_post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_acc_post_cs", 32'(cs), 32'd0);
    chk("rst_acc_tcount", 32'(timeout_count), 32'd0);
    tick();
    chk("rst_acc_post2_rsp_valid", 32'(rsp_valid), 32'd0);
    issue(1'b0, 32'h10, 32'h01020304, 4'hF);
    chk("after_rst_s1_cs", 32'(cs), 32'd1);
    tick();
    tick();
    chk("after_rst_s3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("after_rst_s3_err", 32'(rsp_error), 32'd0);
    tick();

    // Ack in the same cycle the timeout would fire: ack wins
    resp_delay = 3;
    rd_val     = 32'h0BADF00D;
    issue(1'b1, 32'h50, 32'd0, 4'hF);
    for (int i = 1; i <= 4; i++) tick();
    chk("race_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("race_timeout", 32'(rsp_timeout), 32'd0);
    chk("race_rdata", rsp_rdata, 32'h0BADF00D);
    chk("race_tcount", 32'(timeout_count), 32'd0);
    tick();
    resp_delay = 1;

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
